// File: rtl/result_uart_tx.sv
// Buffers 16-bit result words and sends each on an 8N1 UART line (LSB first)
// as four uppercase hex digits followed by a newline.
module result_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   output logic        ready,
   output logic        tx,
   output logic        busy,
   output logic        overflow
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [15:0]   hold_q, hold_d;
   logic [2:0]    char_q, char_d;
   logic [2:0]    bit_q, bit_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          tx_q, tx_d;
   logic          ovf_q;
   logic          full, pop, push, tick_done;
   logic [3:0]    nibble;
   logic [7:0]    char_byte;

   // A pop frees a slot in the same cycle, so a full FIFO can still take a word.
   assign full      = (count_q == CNT_FULL);
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign ready     = !full || pop;
   assign push      = data_valid && ready;
   assign tick_done = (tick_q == TICK_LAST);

   assign tx       = tx_q;
   assign busy     = (state_q != IDLE) || (count_q != '0);
   assign overflow = ovf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
         if (data_valid && !push) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   always_comb begin
      case (char_q)
         3'd1:    nibble = hold_q[11:8];
         3'd2:    nibble = hold_q[7:4];
         3'd3:    nibble = hold_q[3:0];
         default: nibble = hold_q[15:12];
      endcase
      if (char_q == 3'd4)
         char_byte = 8'h0A;
      else if (nibble < 4'd10)
         char_byte = 8'h30 + {4'h0, nibble};
      else
         char_byte = 8'h37 + {4'h0, nibble};
   end

   // tx_d is the level for the next bit slot, so tx stays a clean flop output.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      char_d  = char_q;
      bit_d   = bit_q;
      tick_d  = tick_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d = START;
               hold_d  = mem_q[rd_ptr_q];
               char_d  = 3'd0;
               tick_d  = '0;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (tick_done) begin
               state_d = DATA;
               tick_d  = '0;
               bit_d   = 3'd0;
               tx_d    = char_byte[0];
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         DATA: begin
            if (tick_done) begin
               tick_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = char_byte[bit_q + 3'd1];
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         default: begin
            if (tick_done) begin
               tick_d = '0;
               if (char_q == 3'd4) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end else begin
                  state_d = START;
                  char_d  = char_q + 3'd1;
                  tx_d    = 1'b0;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         char_q  <= 3'd0;
         bit_q   <= 3'd0;
         tick_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         char_q  <= char_d;
         bit_q   <= bit_d;
         tick_q  <= tick_d;
         tx_q    <= tx_d;
      end
   end
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: decodes the UART line and compares the
// characters and their timing against hand-derived expectations.
module tb_result_uart_tx;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        data_valid;
   logic        ready, tx, busy, overflow;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int push_cyc = 0;
   int fall_cyc;

   logic [7:0]  rx_q [$];
   int          st_q [$];
   logic        stp_q [$];
   logic [15:0] burst [8];
   logic        rdy_seen [8];
   logic [15:0] exp_w [8];

   logic [7:0]  mon_b;
   int          mon_st;
   logic        mon_bad;
   int          bad_tx, bad_busy, bad_rdy, bad_ovf;

   result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .ready      (ready),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_char(input logic [15:0] w, input int idx);
      logic [3:0] n;
      if (idx == 4) return 8'h0A;
      n = 4'((w >> (12 - 4 * idx)) & 16'h000F);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return 8'h41 + 8'(n) - 8'd10;
   endfunction

   task automatic mon_wait(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (reset) mon_bad = 1'b1;
      end
   endtask

   // Line decoder: samples each bit mid-slot; frames hit by reset are discarded.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            mon_st  = cyc;
            mon_bad = 1'b0;
            mon_b   = 8'h00;
            mon_wait(5);
            mon_b[0] = tx;
            for (int j = 1; j < 8; j++) begin
               mon_wait(4);
               mon_b[j] = tx;
            end
            mon_wait(4);
            if (!mon_bad) begin
               rx_q.push_back(mon_b);
               st_q.push_back(mon_st);
               stp_q.push_back(tx);
            end
         end
      end
   end

   task automatic clear_rx();
      rx_q.delete();
      st_q.delete();
      stp_q.delete();
   endtask

   task automatic drive_burst(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 1) push_cyc = cyc;
         data_valid  = 1'b1;
         data_in     = burst[i];
         rdy_seen[i] = ready;
      end
      @(posedge clk); #1;
      if (n == 1) push_cyc = cyc;
      data_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int fall);
      fall = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            fall = cyc;
            break;
         end
      end
      if (fall < 0) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_words(input int nw);
      chk("byte_count", 32'(rx_q.size()), 32'(5 * nw));
      for (int i = 0; i < 5 * nw && i < rx_q.size(); i++) begin
         chk($sformatf("char%0d", i), 32'(rx_q[i]), 32'(exp_char(exp_w[i / 5], i % 5)));
         chk($sformatf("stop%0d", i), 32'(stp_q[i]), 32'd1);
         if (i > 0)
            chk($sformatf("gap%0d", i), 32'(st_q[i] - st_q[i-1]), (i % 5 == 0) ? 32'd41 : 32'd40);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, with data_valid asserted to show it is ignored.
      reset = 1'b1; data_valid = 1'b1; data_in = 16'hABCD;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      data_valid = 1'b0; reset = 1'b0;
      bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_ovf = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1)       bad_tx++;
         if (busy !== 1'b0)     bad_busy++;
         if (ready !== 1'b1)    bad_rdy++;
         if (overflow !== 1'b0) bad_ovf++;
      end
      chk("quiet_tx_cycles", 32'(bad_tx), 32'd0);
      chk("quiet_busy_cycles", 32'(bad_busy), 32'd0);
      chk("quiet_ready_cycles", 32'(bad_rdy), 32'd0);
      chk("quiet_ovf_cycles", 32'(bad_ovf), 32'd0);

      // Single word 0x1A2F -> "1A2F\n"
      clear_rx();
      burst[0] = 16'h1A2F; exp_w[0] = 16'h1A2F;
      drive_burst(1);
      chk("busy_after_push", 32'(busy), 32'd1);
      wait_idle(600, fall_cyc);
      chk("busy_fall_delay", 32'(fall_cyc - push_cyc), 32'd201);
      if (st_q.size() > 0) chk("first_start_delay", 32'(st_q[0] - push_cyc), 32'd1);
      check_words(1);
      chk("tx_idle_after", 32'(tx), 32'd1);

      // Back-to-back words 0x0000, 0xFFFF
      clear_rx();
      burst[0] = 16'h0000; burst[1] = 16'hFFFF;
      exp_w[0] = 16'h0000; exp_w[1] = 16'hFFFF;
      drive_burst(2);
      wait_idle(1000, fall_cyc);
      check_words(2);
      chk("ovf_b2b", 32'(overflow), 32'd0);

      // Six words: first popped, four buffered, sixth dropped
      clear_rx();
      for (int i = 0; i < 6; i++) burst[i] = 16'(i + 1);
      for (int i = 0; i < 5; i++) exp_w[i] = 16'(i + 1);
      drive_burst(6);
      chk("ready_w5", 32'(rdy_seen[4]), 32'd1);
      chk("ready_w6_dropped", 32'(rdy_seen[5]), 32'd0);
      chk("ovf_set", 32'(overflow), 32'd1);
      wait_idle(2000, fall_cyc);
      check_words(5);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset in the middle of 0xBEEF ('E' data bit 4 is low at frame cycle 60)
      clear_rx();
      burst[0] = 16'hBEEF;
      drive_burst(1);
      while (cyc != push_cyc + 61) begin
         @(posedge clk); #1;
      end
      chk("mid_frame_tx_low", 32'(tx), 32'd0);
      reset = 1'b1; data_valid = 1'b1; data_in = 16'h5555;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_ovf", 32'(overflow), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      data_valid = 1'b0; reset = 1'b0;
      clear_rx();
      repeat (100) @(negedge clk);
      chk("no_chars_after_abort", 32'(rx_q.size()), 32'd0);
      chk("idle_after_abort", 32'(busy), 32'd0);
      burst[0] = 16'h1234; exp_w[0] = 16'h1234;
      drive_burst(1);
      wait_idle(600, fall_cyc);
      check_words(1);

      // Push on the exact pop cycle of a full FIFO
      clear_rx();
      burst[0] = 16'h89AB; burst[1] = 16'hCDEF; burst[2] = 16'h0123;
      burst[3] = 16'h4567; burst[4] = 16'h7E3C;
      for (int i = 0; i < 5; i++) exp_w[i] = burst[i];
      exp_w[5] = 16'hD00D;
      drive_burst(5);
      chk("full_ready_low", 32'(ready), 32'd0);
      while (cyc != push_cyc + 201) begin
         @(posedge clk); #1;
      end
      data_valid = 1'b1; data_in = 16'hD00D;
      chk("pop_cycle_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      data_valid = 1'b0;
      chk("still_full_ready", 32'(ready), 32'd0);
      chk("pop_push_ovf", 32'(overflow), 32'd0);
      wait_idle(3000, fall_cyc);
      check_words(6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the word-buffer depth (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, 16 bits: the result word from the processor data bus.
REQ-006 SHALL have port data_valid, input, 1 bit: data_in is offered this cycle.
REQ-007 SHALL have port ready, output, 1 bit: a push will be accepted this cycle.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a character frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, at least one word was dropped.

Function
REQ-011 SHALL buffer words in a FIFO_DEPTH-entry FIFO, holding pointers, a count or full/empty flags, with pointers wrapping modulo FIFO_DEPTH.
REQ-012 SHALL accept a push when data_valid=1 and either (FIFO not full) or (FSM pops in the same cycle).
REQ-013 SHALL drive ready = not full OR pop-this-cycle, combinationally.
REQ-014 SHALL, when data_valid=1 and the push is not accepted, drop the word, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-015 SHALL, with the FSM in IDLE and the FIFO non-empty, pop the head word into a 16-bit hold register and set char index to 0.
REQ-016 SHALL emit, per word, 5 characters in order: hex nibbles [15:12], [11:8], [7:4], [3:0], then 0x0A.
REQ-017 SHALL encode each nibble as ASCII: 0-9 map to 0x30-0x39, and A-F map to 0x41-0x46 (uppercase).
REQ-018 SHALL use the FSM states IDLE, START, DATA, STOP.
REQ-019 SHALL make the FSM transitions IDLE->START on pop; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->START when char index < 4 (index increments); STOP->IDLE when char index = 4.
REQ-020 SHALL frame each character as a start bit of 0, 8 data bits LSB first, and a stop bit of 1, each held exactly CLKS_PER_BIT cycles, giving 10*CLKS_PER_BIT cycles per character.
REQ-021 SHALL insert no idle gap between characters of one word, and SHALL insert exactly one IDLE cycle between consecutive words.
REQ-022 SHALL, when a push is sampled at edge N into an empty FIFO with the FSM in IDLE, pop at edge N+1 and drive tx low from edge N+1.
REQ-023 SHALL register tx with no combinational glitches.
REQ-024 SHALL assert busy when state != IDLE or FIFO is non-empty.
REQ-025 SHALL, when a simultaneous push and pop occur on a full FIFO, keep count unchanged and store the new word at the tail.
REQ-026 SHALL hold data_in sampling to the push edge only, so later changes to data_in do not affect a buffered word.

Reset
REQ-027 SHALL, while reset=1, immediately force tx=1, busy=0, overflow=0, FSM=IDLE, FIFO empty (ready=1), pointers, counters and char index to 0.
REQ-028 SHALL, on reset asserted mid-frame, abort the frame with tx high at once, discard all buffered words, and emit no partial character after release.
REQ-029 SHALL ignore data_valid while reset=1 and accept pushes from the first rising edge after reset release.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 SHALL cover: reset, then no stimulus for 100 cycles -> tx=1, busy=0, ready=1, overflow=0 throughout.
REQ-031 SHALL cover: push 0x1A2F once -> tx decodes bytes 0x31, 0x41, 0x32, 0x46, 0x0A; each bit is 4 cycles; total 200 cycles; tx low at edge after push; busy falls after final stop bit.
REQ-032 SHALL cover: push 0x0000 then 0xFFFF on consecutive cycles -> "0000\n" then "FFFF\n" with exactly one IDLE cycle between words; overflow=0.
REQ-033 SHALL cover: push 6 words 0x0001..0x0006 on 6 consecutive cycles -> 0x0001 popped immediately; 0x0002-0x0005 buffered; 0x0006 dropped with ready=0 that cycle; overflow=1; output is words 1-5 only.
REQ-034 SHALL cover: assert reset at cycle 60 of the frame for 0xBEEF -> tx=1 same cycle; after release, no further characters; a new push of 0x1234 emits "1234\n" correctly.
REQ-035 SHALL cover: with the FIFO full, assert data_valid on the exact cycle the FSM pops -> word accepted, ready=1, count stays 4, overflow stays 0, and the word is transmitted last.
